// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_prog
//  Purpose  : Single-clock FIFO with standard/FWFT read modes, exact occupancy,
//             programmable almost-full/almost-empty, flush and sticky errors.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  winc,
    input  logic                  rinc,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [ADDR_WIDTH:0]   afull_thresh,
    input  logic [ADDR_WIDTH:0]   aempty_thresh,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = c_DEPTH[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;

    // Accept decisions look only at the pre-edge count, so a same-cycle read
    // never makes room for a write into a full FIFO (and vice versa).
    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_wr_ok = winc & ~w_full  & ~flush;
    assign w_rd_ok = rinc & ~w_empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_rd_ok) begin
                r_raddr <= r_raddr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A set event in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc & w_full & ~flush) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rinc & w_empty & ~flush) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = r_mem[r_raddr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rdata;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_rd_ok) begin
                    r_rdata <= r_mem[r_raddr];
                end
            end
            assign rdata = r_rdata;
        end
    endgenerate

    assign wfull        = w_full;
    assign rempty       = w_empty;
    assign almost_full  = (r_count >= afull_thresh);
    assign almost_empty = (r_count <= aempty_thresh);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_prog
//  Purpose  : Self-checking bench driving a standard and an FWFT instance in
//             lockstep against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic       winc;
    logic       rinc;
    logic       flush;
    logic       clr_err;
    logic [4:0] afull_thresh;
    logic [4:0] aempty_thresh;

    logic [7:0] rdata_s, rdata_f;
    logic       wfull_s, wfull_f, rempty_s, rempty_f;
    logic       afull_s, afull_f, aempty_s, aempty_f;
    logic [4:0] count_s, count_f;
    logic       ovf_s, ovf_f, udf_s, udf_f;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata;
    logic       m_ovf;
    logic       m_udf;

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
        .flush(flush), .clr_err(clr_err), .afull_thresh(afull_thresh),
        .aempty_thresh(aempty_thresh), .rdata(rdata_s), .wfull(wfull_s),
        .rempty(rempty_s), .almost_full(afull_s), .almost_empty(aempty_s),
        .count(count_s), .overflow(ovf_s), .underflow(udf_s)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
        .flush(flush), .clr_err(clr_err), .afull_thresh(afull_thresh),
        .aempty_thresh(aempty_thresh), .rdata(rdata_f), .wfull(wfull_f),
        .rempty(rempty_f), .almost_full(afull_f), .almost_empty(aempty_f),
        .count(count_f), .overflow(ovf_f), .underflow(udf_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; the model applies the FIFO rules to the queue.
    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic fl, input logic ce);
        bit full;
        bit empty;
        winc = w; rinc = r; wdata = d; flush = fl; clr_err = ce;
        full  = (q.size() == 16);
        empty = (q.size() == 0);
        if (w && full && !fl) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
        if (r && empty && !fl) m_udf = 1'b1; else if (ce) m_udf = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (r && !empty) m_rdata = q.pop_front();
            if (w && !full) q.push_back(d);
        end
        @(posedge clk);
        #1;
        winc = 0; rinc = 0; flush = 0; clr_err = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = 8'h00;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        checks++; if (count_s !== 5'd0 || count_f !== 5'd0) begin errors++;
            $display("FAIL reset_count: got %0d/%0d want 0", count_s, count_f); end
        checks++; if (rempty_s !== 1'b1 || wfull_s !== 1'b0 || rempty_f !== 1'b1) begin errors++;
            $display("FAIL reset_flags: rempty=%b wfull=%b want 1 0", rempty_s, wfull_s); end
        checks++; if (aempty_s !== 1'b1 || afull_s !== 1'b0) begin errors++;
            $display("FAIL reset_almost: aempty=%b afull=%b want 1 0", aempty_s, afull_s); end
        checks++; if (rdata_s !== 8'h00 || ovf_s !== 1'b0 || udf_s !== 1'b0) begin errors++;
            $display("FAIL reset_data_err: rdata=%h ovf=%b udf=%b want 00 0 0", rdata_s, ovf_s, udf_s); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i + 1), 0, 0);
            checks++; if (count_s !== 5'(i + 1)) begin errors++;
                $display("FAIL fill_count: got %0d want %0d", count_s, i + 1); end
        end
        checks++; if (wfull_s !== 1'b1 || wfull_f !== 1'b1 || count_s !== 5'd16) begin errors++;
            $display("FAIL fill_full: wfull=%b count=%0d want 1 16", wfull_s, count_s); end
        for (int i = 0; i < 16; i++) begin
            exp = 8'(i + 1);
            checks++; if (rdata_f !== exp) begin errors++;
                $display("FAIL fwft_head: got %h want %h", rdata_f, exp); end
            step(0, 1, 8'h00, 0, 0);
            checks++; if (rdata_s !== exp) begin errors++;
                $display("FAIL drain_rdata: got %h want %h", rdata_s, exp); end
        end
        checks++; if (rempty_s !== 1'b1 || count_s !== 5'd0 || udf_s !== 1'b0) begin errors++;
            $display("FAIL drain_empty: rempty=%b count=%0d udf=%b want 1 0 0", rempty_s, count_s, udf_s); end
    endtask

    task automatic test_fwft();
        step(1, 0, 8'hA5, 0, 0);
        checks++; if (rempty_f !== 1'b0 || rdata_f !== 8'hA5) begin errors++;
            $display("FAIL fwft_visible: rempty=%b rdata=%h want 0 a5", rempty_f, rdata_f); end
        step(0, 1, 8'h00, 0, 0);
        checks++; if (rempty_f !== 1'b1 || count_f !== 5'd0) begin errors++;
            $display("FAIL fwft_pop: rempty=%b count=%0d want 1 0", rempty_f, count_f); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom), 0, 0);
        step(1, 1, 8'hEE, 0, 0);
        checks++; if (count_s !== 5'd15 || ovf_s !== 1'b1 || ovf_f !== 1'b1) begin errors++;
            $display("FAIL full_rw: count=%0d ovf=%b want 15 1", count_s, ovf_s); end
        checks++; if (rdata_s !== m_rdata) begin errors++;
            $display("FAIL full_rw_rdata: got %h want %h", rdata_s, m_rdata); end
        step(0, 0, 8'h00, 0, 1);
        checks++; if (ovf_s !== 1'b0 || count_s !== 5'd15) begin errors++;
            $display("FAIL clr_err: ovf=%b count=%0d want 0 15", ovf_s, count_s); end
        step(0, 0, 8'h00, 1, 0);
    endtask

    task automatic test_simul_empty();
        logic [7:0] d;
        step(1, 1, 8'h11, 0, 0);
        checks++; if (count_s !== 5'd1 || udf_s !== 1'b1 || udf_f !== 1'b1) begin errors++;
            $display("FAIL empty_rw: count=%0d udf=%b want 1 1", count_s, udf_s); end
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            step(1, 1, d, 0, 0);
            checks++; if (count_s !== 5'd1 || rdata_s !== m_rdata || rdata_f !== d) begin errors++;
                $display("FAIL wrap_rw: count=%0d rdata=%h fwft=%h want 1 %h %h",
                         count_s, rdata_s, rdata_f, m_rdata, d); end
        end
        step(0, 0, 8'h00, 1, 1);
        checks++; if (udf_s !== 1'b0 || count_s !== 5'd0) begin errors++;
            $display("FAIL flush_clr: udf=%b count=%0d want 0 0", udf_s, count_s); end
    endtask

    task automatic test_thresholds();
        afull_thresh  = 5'd12;
        aempty_thresh = 5'd3;
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 8'(i), 0, 0);
            checks++; if (aempty_s !== (i <= 3) || afull_s !== (i >= 12)) begin errors++;
                $display("FAIL thresh_n%0d: aempty=%b afull=%b want %b %b",
                         i, aempty_s, afull_s, (i <= 3), (i >= 12)); end
        end
        step(1, 0, 8'h77, 1, 0);
        checks++; if (count_s !== 5'd0 || rempty_s !== 1'b1 || aempty_s !== 1'b1) begin errors++;
            $display("FAIL flush_w: count=%0d rempty=%b aempty=%b want 0 1 1", count_s, rempty_s, aempty_s); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h50 + i), 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(1, 0, 8'h99, 0, 0);
        checks++; if (count_s !== 5'd7 || rdata_s !== 8'h50) begin errors++;
            $display("FAIL pre_reset: count=%0d rdata=%h want 7 50", count_s, rdata_s); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (count_s !== 5'd0 || rempty_s !== 1'b1 || rdata_s !== 8'h00) begin errors++;
            $display("FAIL async_reset: count=%0d rempty=%b rdata=%h want 0 1 00", count_s, rempty_s, rdata_s); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 8'h3C, 0, 0);
        checks++; if (rdata_f !== 8'h3C) begin errors++;
            $display("FAIL post_reset_fwft: got %h want 3c", rdata_f); end
        step(0, 1, 8'h00, 0, 0);
        checks++; if (rdata_s !== 8'h3C || rempty_s !== 1'b1) begin errors++;
            $display("FAIL post_reset_read: rdata=%h rempty=%b want 3c 1", rdata_s, rempty_s); end
    endtask

    task automatic test_random();
        int wpct;
        logic [4:0] sz;
        for (int i = 0; i < 400; i++) begin
            wpct = (i % 100 < 50) ? 75 : 30;
            afull_thresh  = 5'($urandom_range(16, 1));
            aempty_thresh = 5'($urandom_range(15, 0));
            step($urandom_range(99) < wpct, $urandom_range(99) < 100 - wpct,
                 8'($urandom), $urandom_range(99) < 3, $urandom_range(99) < 8);
            sz = 5'(q.size());
            checks++; if (count_s !== sz || count_f !== sz) begin errors++;
                $display("FAIL rnd_count: got %0d/%0d want %0d", count_s, count_f, sz); end
            checks++; if (wfull_s !== (sz == 16) || rempty_s !== (sz == 0) ||
                          afull_s !== (sz >= afull_thresh) || aempty_s !== (sz <= aempty_thresh)) begin errors++;
                $display("FAIL rnd_flags: full=%b empty=%b af=%b ae=%b count=%0d",
                         wfull_s, rempty_s, afull_s, aempty_s, sz); end
            checks++; if (ovf_s !== m_ovf || udf_s !== m_udf || ovf_f !== m_ovf || udf_f !== m_udf) begin errors++;
                $display("FAIL rnd_err: ovf=%b udf=%b want %b %b", ovf_s, udf_s, m_ovf, m_udf); end
            checks++; if (rdata_s !== m_rdata) begin errors++;
                $display("FAIL rnd_rdata: got %h want %h", rdata_s, m_rdata); end
            if (sz != 0) begin
                checks++; if (rdata_f !== q[0]) begin errors++;
                    $display("FAIL rnd_fwft: got %h want %h", rdata_f, q[0]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; wdata = 8'h00; winc = 0; rinc = 0; flush = 0; clr_err = 0;
        afull_thresh = 5'd16; aempty_thresh = 5'd0;
        model_reset();
        test_reset();
        test_fill_drain();
        test_fwft();
        test_simul_full();
        test_simul_empty();
        test_thresholds();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering. Adds a selectable first-word-fall-through (FWFT) read mode and an exact occupancy count. Adds programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Sits between same-clock producer/consumer stages; no pointer synchronisers or Gray coding are needed.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default)
FWFT, 0, 0 = standard mode (registered read data); 1 = first-word-fall-through mode

Ports:
clk  input  1  single FIFO clock; all logic samples on the rising edge
rst_n  input  1  asynchronous active-low reset
wdata  input  DATA_WIDTH  write data
winc  input  1  write request
rinc  input  1  read request (standard mode) / pop (FWFT mode)
flush  input  1  synchronous clear of FIFO contents
clr_err  input  1  synchronous clear of the sticky error flags
afull_thresh  input  ADDR_WIDTH+1  almost-full level; legal range 1..DEPTH
aempty_thresh  input  ADDR_WIDTH+1  almost-empty level; legal range 0..DEPTH-1
rdata  output  DATA_WIDTH  read data
wfull  output  1  FIFO full (count == DEPTH)
rempty  output  1  FIFO empty (count == 0)
almost_full  output  1  count >= afull_thresh
almost_empty  output  1  count <= aempty_thresh
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Storage: DEPTH x DATA_WIDTH array. Read is combinational from the array; write is synchronous.
- Pointers: waddr and raddr are ADDR_WIDTH bits each, binary, and wrap from DEPTH-1 to 0. count is a registered ADDR_WIDTH+1-bit value.
- Write accept: wr_ok = winc & ~wfull. Each accepted write stores wdata at waddr and increments waddr.
- Read accept: rd_ok = rinc & ~rempty. Each accepted read increments raddr.
- Full/empty decisions use the pre-edge state only:
  - Write while full is rejected, even when rd_ok is true in the same cycle.
  - Read while empty is rejected, even when winc is true in the same cycle.
- Count update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Flags: wfull, rempty, almost_full and almost_empty are combinational decodes of the registered count. No extra latency after count updates.
- Standard mode (FWFT=0):
  - On rd_ok, rdata <= mem[raddr], visible the cycle after rinc.
  - rdata holds its value otherwise.
  - Write-to-rempty-deassert latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rdata = mem[raddr] combinationally whenever rempty=0; the head word is visible with no rinc.
  - rinc pops the head; the next word appears in the following cycle.
  - rdata is don't-care while rempty=1.
- Flush: if flush=1 at an edge, waddr, raddr and count go to 0 and any same-cycle winc/rinc is ignored. Flush has priority over write/read. Array contents are not cleared. Error flags are unaffected by flush.
- Errors:
  - overflow is set at an edge where winc & wfull & ~flush.
  - underflow is set at an edge where rinc & rempty & ~flush.
  - Both flags hold until clr_err=1 or reset. If a set event and clr_err occur in the same cycle, set wins.
- Reset (rst_n=0, asynchronous assert): waddr=0, raddr=0, count=0, rdata=0, overflow=0, underflow=0. Resulting outputs: rempty=1, wfull=0, almost_empty=1, almost_full=0 for legal thresholds.
- Reset mid-operation discards all contents immediately. The first edge after deassert is a normal cycle.
- Thresholds are sampled continuously and may change at any time; the flags follow combinationally. Out-of-range thresholds are not checked and give undefined flag meaning.

Test Plan:
1. Reset, then write 0x01..0x10 (16 words) in standard mode -> wfull=1 and count=16 after the 16th edge. Then read 16 -> rdata 0x01..0x10 in order, each 1 cycle after rinc; rempty=1 and count=0 at end.
2. FWFT=1, write 0xA5 once -> next cycle rempty=0 and rdata=0xA5 with rinc=0. Pulse rinc -> rempty=1, count=0.
3. Full FIFO, assert winc=1 and rinc=1 together -> read accepted, write rejected, count 16->15, overflow=1. Then clr_err -> overflow=0.
4. Empty FIFO, assert winc=1 and rinc=1 together -> count 0->1, underflow=1. Continuous winc=rinc=1 for 40 cycles afterwards -> count stays 1 and both pointers wrap cleanly.
5. afull_thresh=12, aempty_thresh=3, write 12 words -> almost_empty drops after the 4th write and almost_full rises after the 12th. Then flush with winc=1 -> count=0, rempty=1, almost_empty=1.
6. Assert rst_n=0 mid-stream at count=7 -> count=0, rempty=1, rdata=0 immediately, without waiting for a clock edge. After release, write/read 0x3C -> rdata=0x3C.
